// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control sequencer with memory handshake, retire counter and halt
module multicycle_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           opcode,
   input  logic                 mem_ready,
   output logic                 pc_write,
   output logic                 branch_eq,
   output logic                 branch_ne,
   output logic                 iord,
   output logic                 memread,
   output logic                 memwrite,
   output logic                 memtoreg,
   output logic                 ir_write,
   output logic                 regdst,
   output logic                 regwrite,
   output logic                 alusrc_a,
   output logic [1:0]           alusrc_b,
   output logic [1:0]           aluop,
   output logic [1:0]           pc_source,
   output logic [3:0]           state,
   output logic [CNT_WIDTH-1:0] retired,
   output logic                 halted,
   output logic [1:0]           halt_cause
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_RWB     = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_ADDI_EX = 4'd11,
      S_ADDI_WB = 4'd12,
      S_HALT    = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

   state_t        cur;
   logic [WW-1:0] wait_cnt;

   assign state = cur;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur        <= S_IDLE;
         retired    <= '0;
         halted     <= 1'b0;
         halt_cause <= 2'b00;
         wait_cnt   <= '0;
      end else begin
         case (cur)
            S_IDLE: cur <= S_FETCH;
            // wait_cnt holds cycles already waited; the MEM_TIMEOUT-th idle cycle halts unless ready
            S_FETCH, S_MEMRD, S_MEMWR: begin
               if (mem_ready) begin
                  wait_cnt <= '0;
                  case (cur)
                     S_FETCH: cur <= S_DECODE;
                     S_MEMRD: cur <= S_MEMWB;
                     default: begin
                        cur     <= S_FETCH;
                        retired <= retired + CNT_WIDTH'(1);
                     end
                  endcase
               end else if (wait_cnt == WAIT_LAST) begin
                  cur        <= S_HALT;
                  halted     <= 1'b1;
                  halt_cause <= 2'b10;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            S_DECODE: begin
               case (opcode)
                  OP_RTYPE:      cur <= S_EXEC;
                  OP_LW, OP_SW:  cur <= S_MEMADR;
                  OP_BEQ, OP_BNE: cur <= S_BRANCH;
                  OP_J:          cur <= S_JUMP;
                  OP_ADDI:       cur <= S_ADDI_EX;
                  default: begin
                     cur        <= S_HALT;
                     halted     <= 1'b1;
                     halt_cause <= 2'b01;
                  end
               endcase
            end
            S_MEMADR:  cur <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_EXEC:    cur <= S_RWB;
            S_ADDI_EX: cur <= S_ADDI_WB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
               cur     <= S_FETCH;
               retired <= retired + CNT_WIDTH'(1);
            end
            S_HALT:  cur <= S_HALT;
            default: cur <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      pc_write  = 1'b0;
      branch_eq = 1'b0;
      branch_ne = 1'b0;
      iord      = 1'b0;
      memread   = 1'b0;
      memwrite  = 1'b0;
      memtoreg  = 1'b0;
      ir_write  = 1'b0;
      regdst    = 1'b0;
      regwrite  = 1'b0;
      alusrc_a  = 1'b0;
      alusrc_b  = 2'b00;
      aluop     = 2'b00;
      pc_source = 2'b00;
      case (cur)
         S_FETCH: begin
            memread  = 1'b1;
            alusrc_b = 2'b01;
            pc_write = mem_ready;
            ir_write = mem_ready;
         end
         S_DECODE:  alusrc_b = 2'b11;
         S_MEMADR, S_ADDI_EX: begin
            alusrc_a = 1'b1;
            alusrc_b = 2'b10;
         end
         S_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
         end
         S_EXEC: begin
            alusrc_a = 1'b1;
            aluop    = 2'b10;
         end
         S_RWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         S_BRANCH: begin
            alusrc_a  = 1'b1;
            aluop     = 2'b01;
            pc_source = 2'b01;
            branch_eq = (opcode == OP_BEQ);
            branch_ne = (opcode == OP_BNE);
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_ADDI_WB: regwrite = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        pc_write, branch_eq, branch_ne, iord, memread, memwrite;
   logic        memtoreg, ir_write, regdst, regwrite, alusrc_a;
   logic [1:0]  alusrc_b, aluop, pc_source;
   logic [3:0]  state;
   logic [31:0] retired;
   logic        halted;
   logic [1:0]  halt_cause;

   multicycle_control #(.MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne),
      .iord(iord), .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
      .ir_write(ir_write), .regdst(regdst), .regwrite(regwrite),
      .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop),
      .pc_source(pc_source), .state(state), .retired(retired),
      .halted(halted), .halt_cause(halt_cause)
   );

   always #5 clk = ~clk;

   // observed vector: {state, 17 control bits, halted, halt_cause, retired}
   logic [55:0] obs;
   assign obs = {state, pc_write, branch_eq, branch_ne, iord, memread, memwrite,
                 memtoreg, ir_write, regdst, regwrite, alusrc_a, alusrc_b, aluop,
                 pc_source, halted, halt_cause, retired};

   // control fields: pcw beq bne iord mrd mwr m2r irw rdst rw asa asb aop psrc
   localparam logic [16:0] C_ZERO    = 17'b0_0_0_0_0_0_0_0_0_0_0_00_00_00;
   localparam logic [16:0] C_FETCH_R = 17'b1_0_0_0_1_0_0_1_0_0_0_01_00_00;
   localparam logic [16:0] C_FETCH_W = 17'b0_0_0_0_1_0_0_0_0_0_0_01_00_00;
   localparam logic [16:0] C_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
   localparam logic [16:0] C_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
   localparam logic [16:0] C_MEMRD   = 17'b0_0_0_1_1_0_0_0_0_0_0_00_00_00;
   localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_0_0_1_0_0_1_0_00_00_00;
   localparam logic [16:0] C_MEMWR   = 17'b0_0_0_1_0_1_0_0_0_0_0_00_00_00;
   localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_0_0_0_0_1_00_10_00;
   localparam logic [16:0] C_RWB     = 17'b0_0_0_0_0_0_0_0_1_1_0_00_00_00;
   localparam logic [16:0] C_BEQ     = 17'b0_1_0_0_0_0_0_0_0_0_1_00_01_01;
   localparam logic [16:0] C_BNE     = 17'b0_0_1_0_0_0_0_0_0_0_1_00_01_01;
   localparam logic [16:0] C_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_10;
   localparam logic [16:0] C_ADDI_EX = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
   localparam logic [16:0] C_ADDI_WB = 17'b0_0_0_0_0_0_0_0_0_1_0_00_00_00;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000, OP_BAD = 6'b111111;

   typedef struct packed {
      logic       rst;
      logic [5:0] op;
      logic       mr;
   } stim_t;

   stim_t       stim_q[$];
   logic [55:0] sb_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   // queue one cycle: inputs driven this cycle and the outputs expected during it
   task automatic put(input logic rst, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input logic [16:0] c,
                      input logic h, input logic [1:0] hc, input logic [31:0] r);
      stim_q.push_back('{rst: rst, op: op, mr: mr});
      sb_q.push_back({st, c, h, hc, r});
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic test_reset();
      stim_t s; logic [55:0] e; int n = 0;
      put(1, OP_R, 0, 0, C_ZERO, 0, 0, 0);
      put(1, OP_R, 1, 0, C_ZERO, 0, 0, 0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); reset = s.rst; opcode = s.op; mem_ready = s.mr;
         @(negedge clk);
         e = sb_q.pop_front(); vectors++;
         if (obs !== e) begin miscompares++; $display("FAIL reset step %0d: got %h expected %h", n, obs, e); end
         n++; @(posedge clk); #1;
      end
   endtask

   task automatic test_rtype();
      stim_t s; logic [55:0] e; int n = 0;
      put(0, OP_R, 1, 0, C_ZERO,    0, 0, 0);
      put(0, OP_R, 1, 1, C_FETCH_R, 0, 0, 0);
      put(0, OP_R, 1, 2, C_DECODE,  0, 0, 0);
      put(0, OP_R, 1, 7, C_EXEC,    0, 0, 0);
      put(0, OP_R, 1, 8, C_RWB,     0, 0, 0);
      put(0, OP_R, 1, 1, C_FETCH_R, 0, 0, 1);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); reset = s.rst; opcode = s.op; mem_ready = s.mr;
         @(negedge clk);
         e = sb_q.pop_front(); vectors++;
         if (obs !== e) begin miscompares++; $display("FAIL rtype step %0d: got %h expected %h", n, obs, e); end
         n++; @(posedge clk); #1;
      end
   endtask

   task automatic test_lw_wait();
      stim_t s; logic [55:0] e; int n = 0;
      put(0, OP_LW, 0, 2, C_DECODE, 0, 0, 1);
      put(0, OP_LW, 0, 3, C_MEMADR, 0, 0, 1);
      for (int i = 0; i < 3; i++) put(0, OP_LW, 0, 4, C_MEMRD, 0, 0, 1);
      put(0, OP_LW, 1, 4, C_MEMRD,  0, 0, 1);
      put(0, OP_LW, 0, 5, C_MEMWB,  0, 0, 1);
      put(0, OP_LW, 1, 1, C_FETCH_R, 0, 0, 2);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); reset = s.rst; opcode = s.op; mem_ready = s.mr;
         @(negedge clk);
         e = sb_q.pop_front(); vectors++;
         if (obs !== e) begin miscompares++; $display("FAIL lw_wait step %0d: got %h expected %h", n, obs, e); end
         n++; @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_jump();
      stim_t s; logic [55:0] e; int n = 0;
      put(0, OP_BEQ, rnd(), 2,  C_DECODE,  0, 0, 2);
      put(0, OP_BEQ, rnd(), 9,  C_BEQ,     0, 0, 2);
      put(0, OP_BNE, 1,     1,  C_FETCH_R, 0, 0, 3);
      put(0, OP_BNE, rnd(), 2,  C_DECODE,  0, 0, 3);
      put(0, OP_BNE, rnd(), 9,  C_BNE,     0, 0, 3);
      put(0, OP_J,   1,     1,  C_FETCH_R, 0, 0, 4);
      put(0, OP_J,   rnd(), 2,  C_DECODE,  0, 0, 4);
      put(0, OP_J,   rnd(), 10, C_JUMP,    0, 0, 4);
      put(0, OP_J,   1,     1,  C_FETCH_R, 0, 0, 5);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); reset = s.rst; opcode = s.op; mem_ready = s.mr;
         @(negedge clk);
         e = sb_q.pop_front(); vectors++;
         if (obs !== e) begin miscompares++; $display("FAIL branch_jump step %0d: got %h expected %h", n, obs, e); end
         n++; @(posedge clk); #1;
      end
   endtask

   task automatic test_addi_sw();
      stim_t s; logic [55:0] e; int n = 0;
      put(0, OP_ADDI, rnd(), 2,  C_DECODE,  0, 0, 5);
      put(0, OP_ADDI, rnd(), 11, C_ADDI_EX, 0, 0, 5);
      put(0, OP_ADDI, rnd(), 12, C_ADDI_WB, 0, 0, 5);
      put(0, OP_SW,   1,     1,  C_FETCH_R, 0, 0, 6);
      put(0, OP_SW,   rnd(), 2,  C_DECODE,  0, 0, 6);
      put(0, OP_SW,   rnd(), 3,  C_MEMADR,  0, 0, 6);
      put(0, OP_SW,   0,     6,  C_MEMWR,   0, 0, 6);
      put(0, OP_SW,   1,     6,  C_MEMWR,   0, 0, 6);
      put(0, OP_BAD,  1,     1,  C_FETCH_R, 0, 0, 7);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); reset = s.rst; opcode = s.op; mem_ready = s.mr;
         @(negedge clk);
         e = sb_q.pop_front(); vectors++;
         if (obs !== e) begin miscompares++; $display("FAIL addi_sw step %0d: got %h expected %h", n, obs, e); end
         n++; @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      stim_t s; logic [55:0] e; int n = 0;
      put(0, OP_BAD, rnd(), 2, C_DECODE, 0, 0, 7);
      for (int i = 0; i < 20; i++) put(0, OP_R, rnd(), 15, C_ZERO, 1, 2'b01, 7);
      put(1, OP_SW, 1, 15, C_ZERO,    1, 2'b01, 7);
      put(0, OP_SW, 1, 0,  C_ZERO,    0, 0, 0);
      put(0, OP_SW, 1, 1,  C_FETCH_R, 0, 0, 0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); reset = s.rst; opcode = s.op; mem_ready = s.mr;
         @(negedge clk);
         e = sb_q.pop_front(); vectors++;
         if (obs !== e) begin miscompares++; $display("FAIL illegal step %0d: got %h expected %h", n, obs, e); end
         n++; @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_midwait();
      stim_t s; logic [55:0] e; int n = 0;
      put(0, OP_SW, 0, 2, C_DECODE,  0, 0, 0);
      put(0, OP_SW, 0, 3, C_MEMADR,  0, 0, 0);
      put(0, OP_SW, 1, 6, C_MEMWR,   0, 0, 0);
      put(0, OP_SW, 1, 1, C_FETCH_R, 0, 0, 1);
      put(0, OP_SW, 0, 2, C_DECODE,  0, 0, 1);
      put(0, OP_SW, 0, 3, C_MEMADR,  0, 0, 1);
      put(0, OP_SW, 0, 6, C_MEMWR,   0, 0, 1);
      put(1, OP_SW, 0, 6, C_MEMWR,   0, 0, 1);
      put(0, OP_SW, 1, 0, C_ZERO,    0, 0, 0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); reset = s.rst; opcode = s.op; mem_ready = s.mr;
         @(negedge clk);
         e = sb_q.pop_front(); vectors++;
         if (obs !== e) begin miscompares++; $display("FAIL reset_midwait step %0d: got %h expected %h", n, obs, e); end
         n++; @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      stim_t s; logic [55:0] e; int n = 0;
      for (int i = 0; i < 16; i++) put(0, OP_R, 0, 1, C_FETCH_W, 0, 0, 0);
      put(1, OP_R, 1, 15, C_ZERO, 1, 2'b10, 0);
      put(0, OP_R, 0, 0,  C_ZERO, 0, 0, 0);
      for (int i = 0; i < 15; i++) put(0, OP_R, 0, 1, C_FETCH_W, 0, 0, 0);
      put(0, OP_R, 1, 1, C_FETCH_R, 0, 0, 0);
      put(0, OP_R, 0, 2, C_DECODE,  0, 0, 0);
      put(0, OP_R, 0, 7, C_EXEC,    0, 0, 0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); reset = s.rst; opcode = s.op; mem_ready = s.mr;
         @(negedge clk);
         e = sb_q.pop_front(); vectors++;
         if (obs !== e) begin miscompares++; $display("FAIL timeout step %0d: got %h expected %h", n, obs, e); end
         n++; @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; opcode = OP_R; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_branch_jump();
      test_addi_sw();
      test_illegal();
      test_reset_midwait();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
